// File: rtl/muldiv_sequencer.sv
// Purpose: multi-cycle RV32M multiply/divide unit that stalls the datapath until its result is ready.
// Latency: normal op XLEN+2 cycles from accept to done (CALC x XLEN, FIXUP, DONE); divide-by-zero/overflow 2 cycles.
// Backpressure: stall_o holds PC/regwen while start_i is high and the unit has not reached DONE; kill_i aborts.
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/funct3_i/rs1_val_i/rs2_val_i request;
//        kill_i flush; stall_o combinational hold; busy_o/done_o/result_o registered status and result.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd_q;     // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [2*XLEN-1:0] acc_q;      // mul: {hi, multiplier/lo}; div: {rem, quot}
    logic [CW-1:0]     cnt_q;
    logic              res_neg_q;
    logic              rem_neg_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // Operand decode at accept time
    logic              is_div, a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;

    always_comb begin
        is_div   = funct3_i[2];
        a_signed = (funct3_i != 3'b011) && (funct3_i != 3'b101) && (funct3_i != 3'b111);
        b_signed = a_signed && (funct3_i != 3'b010);
        neg_a    = a_signed && rs1_val_i[XLEN-1];
        neg_b    = b_signed && rs2_val_i[XLEN-1];
        mag_a    = neg_a ? (~rs1_val_i + 1'b1) : rs1_val_i;
        mag_b    = neg_b ? (~rs2_val_i + 1'b1) : rs2_val_i;
        div_zero = is_div && (rs2_val_i == '0);
        div_ovf  = is_div && b_signed && (rs1_val_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (rs2_val_i == {XLEN{1'b1}});
    end

    // One iteration of shift-add multiply or restoring divide
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0] iter_d;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        iter_d   = {mul_sum, acc_q[XLEN-1:1]};
        if (op_q[2]) begin
            // rem_sh < 2*divisor, so the top bit of the difference is a clean borrow flag
            if (!rem_diff[XLEN]) begin
                iter_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                iter_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign correction and output select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, result_d;

    always_comb begin
        prod_fix = res_neg_q ? (~acc_q + 1'b1) : acc_q;
        quot_fix = res_neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix  = rem_neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quot_fix;
            default:                result_d = rem_fix;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else if (kill_i && (state_q != IDLE)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i && !kill_i) begin
                        op_q   <= funct3_i;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (div_zero) begin
                            // Final values loaded directly; no sign correction applies
                            acc_q     <= {rs1_val_i, {XLEN{1'b1}}};
                            res_neg_q <= 1'b0;
                            rem_neg_q <= 1'b0;
                            state_q   <= FIXUP;
                        end else if (div_ovf) begin
                            acc_q     <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                            res_neg_q <= 1'b0;
                            rem_neg_q <= 1'b0;
                            state_q   <= FIXUP;
                        end else begin
                            acc_q     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                            opnd_q    <= is_div ? mag_b : mag_a;
                            res_neg_q <= neg_a ^ neg_b;
                            rem_neg_q <= neg_a;
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= iter_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    result_q <= result_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin
                    // DONE always returns to IDLE so a held start cannot retrigger
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall_o  = start_i && (state_q != DONE) && rst_ni;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Purpose: self-checking bench for muldiv_sequencer with directed and random operations.
// Latency: checks done timing relative to the accepting edge for normal and bypass operations.
// Backpressure: drives start held like a stalled datapath and checks stall/busy cycle counts.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        kill;
    logic        stall, busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .start_i   (start),
        .funct3_i  (funct3),
        .rs1_val_i (rs1),
        .rs2_val_i (rs2),
        .kill_i    (kill),
        .stall_o   (stall),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        logic [31:0] r;
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else r = 32'(sa / sb);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else r = 32'(sa % sb);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one op with start held until done; caller is just after a negedge.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit hold, input string tag);
        bit spec;
        int exp_lat, stalls, busys, lat;
        spec    = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp_lat = spec ? 2 : 34;
        start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        stalls = 0; busys = 0; lat = -1;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (done) begin
                lat = c;
                break;
            end
            stalls += int'(stall);
            busys  += int'(busy);
            @(negedge clk);
            // Operands change after accept; the unit must ignore them
            rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom_range(0, 7));
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, result, exp);
        chk({tag, " stall@done"}, 32'(stall), 32'd0);
        chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat));
        chk({tag, " busy cycles"}, 32'(busys), 32'(exp_lat - 1));
        last_result = exp;
        start = hold;
        @(negedge clk);
        #1;
        chk({tag, " done pulse end"}, 32'(done), 32'd0);
        chk({tag, " busy idle"}, 32'(busy), 32'd0);
        chk({tag, " stall idle"}, 32'(stall), 32'(hold));
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        rst_ni = 1'b0; start = 1'b1; kill = 1'b0;
        funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        last_result = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        #1;

        // Directed operations
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "MUL 7*-3");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "MULH");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "MULHU");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "MULHSU");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "DIV -7/2");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "REM -7/2");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 0, "DIVU 100/7");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, 0, "REMU 100/7");
        do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "DIVU 5/0");
        do_op(3'd6, 32'd5, 32'd0, 32'd5, 0, "REM 5/0");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "DIV ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "REM ovf");

        // Kill at CALC iteration 10
        start = 1'b1; funct3 = 3'd0; rs1 = 32'd1234; rs2 = 32'd5678;
        repeat (11) @(negedge clk);
        #1;
        chk("kill busy before", 32'(busy), 32'd1);
        kill = 1'b1;
        @(negedge clk);
        #1;
        kill = 1'b0;
        chk("kill busy after", 32'(busy), 32'd0);
        chk("kill no done", 32'(done), 32'd0);
        chk("kill result kept", result, last_result);
        do_op(3'd0, 32'd3, 32'd4, 32'd12, 0, "MUL 3*4 after kill");

        // Asynchronous reset mid-CALC
        start = 1'b1; funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd5;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst result", result, 32'd0);
        chk("arst stall", 32'(stall), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_ni = 1'b1;
        #1;
        do_op(3'd5, 32'd9, 32'd3, 32'd3, 0, "DIVU 9/3 after reset");

        // Back-to-back with start held across both instructions
        do_op(3'd0, 32'd2, 32'd3, 32'd6, 1, "b2b MUL 2*3");
        do_op(3'd5, 32'd6, 32'd2, 32'd3, 0, "b2b DIVU 6/2");

        // Random operations against the reference model
        for (int i = 0; i < 20; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            do_op(rf3, ra, rb, ref_op(rf3, ra, rb), 0, $sformatf("rand%0d f3=%0d", i, rf3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
